// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS control unit (addiu/addu/sw): fetch handshake, decode, ALU control and datapath enables.
// Optional lw support is enabled by defining MIPS_MC_CTRL_LW_EN.
module mips_mc_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int RET_CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          mem_rdata,
  input  logic                 mem_ack,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [31:0]          ir,
  output logic [31:0]          imm_ext,
  output logic [3:0]           alu_ctrl,
  output logic                 alu_src_imm,
  output logic                 reg_write,
  output logic                 reg_dst_rd,
  output logic                 mem_to_reg,
  output logic                 pc_write,
  output logic                 illegal,
  output logic                 timeout,
  output logic [RET_CNT_W-1:0] retired
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_t;
  typedef enum logic [1:0] {C_ADDIU, C_ADDU, C_SW, C_LW} cls_t;

  state_t            state, state_nxt;
  cls_t              cls, dec_cls;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
  logic              wait_hit;
  logic              dec_legal, dec_src, dec_dst;
  logic [3:0]        dec_alu;
  logic              ir_load, dec_load, ill_set, to_set, ret_inc;

  // mem_req/mem_we decode the state directly so an async reset drops them at once
  assign mem_req = rst_n & ((state == S_FETCH) | (state == S_MEM));
  assign mem_we  = rst_n & (state == S_MEM) & (cls == C_SW);
  assign imm_ext = {{16{ir[15]}}, ir[15:0]};

  // The request that has already waited MEM_TIMEOUT-1 cycles traps if this cycle also lacks ack
  assign wait_hit = (MEM_TIMEOUT != 0) && (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_ADDIU;
    dec_alu   = 4'b0000;
    dec_src   = 1'b1;
    dec_dst   = 1'b0;
    case (ir[31:26])
      6'b000000: begin
        if (ir[5:0] == 6'b100001) begin
          dec_cls = C_ADDU;
          dec_alu = 4'b0010;
          dec_src = 1'b0;
          dec_dst = 1'b1;
        end else begin
          dec_legal = 1'b0;
        end
      end
      6'b001001: dec_cls = C_ADDIU;
      6'b101011: begin
        dec_cls = C_SW;
        dec_alu = 4'b0001;
      end
`ifdef MIPS_MC_CTRL_LW_EN
      6'b100011: begin
        dec_cls = C_LW;
        dec_alu = 4'b0001;
      end
`endif
      default: dec_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    ir_load      = 1'b0;
    dec_load     = 1'b0;
    ill_set      = 1'b0;
    to_set       = 1'b0;
    ret_inc      = 1'b0;
    case (state)
      S_FETCH, S_MEM: begin
        if (mem_ack) begin
          wait_cnt_nxt = '0;
          if (state == S_FETCH) begin
            ir_load   = 1'b1;
            state_nxt = S_DECODE;
          end else if (cls == C_LW) begin
            state_nxt = S_WB;
          end else begin
            ret_inc   = 1'b1;
            state_nxt = S_FETCH;
          end
        end else if (wait_hit) begin
          to_set    = 1'b1;
          state_nxt = S_TRAP;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          dec_load  = 1'b1;
          state_nxt = S_EXEC;
        end else begin
          ill_set   = 1'b1;
          state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        wait_cnt_nxt = '0;
        state_nxt    = ((cls == C_SW) || (cls == C_LW)) ? S_MEM : S_WB;
      end
      S_WB: begin
        wait_cnt_nxt = '0;
        ret_inc      = 1'b1;
        state_nxt    = S_FETCH;
      end
      S_TRAP:  state_nxt = S_TRAP;
      default: state_nxt = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_FETCH;
      wait_cnt    <= '0;
      ir          <= '0;
      cls         <= C_ADDIU;
      alu_ctrl    <= 4'b0000;
      alu_src_imm <= 1'b0;
      reg_dst_rd  <= 1'b0;
      pc_write    <= 1'b0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
      timeout     <= 1'b0;
      retired     <= '0;
    end else begin
      state     <= state_nxt;
      wait_cnt  <= wait_cnt_nxt;
      pc_write  <= ir_load;
      reg_write <= (state_nxt == S_WB);
      if (ir_load) ir <= mem_rdata;
      if (dec_load) begin
        cls         <= dec_cls;
        alu_ctrl    <= dec_alu;
        alu_src_imm <= dec_src;
        reg_dst_rd  <= dec_dst;
      end
      if (ill_set) illegal <= 1'b1;
      if (to_set)  timeout <= 1'b1;
      if (ret_inc) retired <= retired + RET_CNT_W'(1);
    end
  end

`ifdef MIPS_MC_CTRL_LW_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mem_to_reg <= 1'b0;
    else        mem_to_reg <= (state_nxt == S_WB) && (cls == C_LW);
  end
`else
  assign mem_to_reg = 1'b0;
`endif

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Bench for mips_mc_ctrl: script-based instruction model, reactive memory, directed and random phases.
module tb_mips_mc_ctrl;
  localparam int TO = 4;
  localparam int RW = 2;

  localparam int K_FETCH = 0, K_DEC = 1, K_EXEC = 2, K_MEMW = 3, K_MEMR = 4, K_WB = 5, K_TRAP = 6;
  localparam int CL_ADDIU = 0, CL_ADDU = 1, CL_SW = 2, CL_LW = 3, CL_ILL = 4;

  logic          clk, rst_n, mem_ack, mem_req, mem_we;
  logic [31:0]   mem_rdata, ir, imm_ext;
  logic [3:0]    alu_ctrl;
  logic          alu_src_imm, reg_write, reg_dst_rd, mem_to_reg, pc_write, illegal, timeout;
  logic [RW-1:0] retired;

  mips_mc_ctrl #(.MEM_TIMEOUT(TO), .RET_CNT_W(RW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .ir(ir), .imm_ext(imm_ext),
    .alu_ctrl(alu_ctrl), .alu_src_imm(alu_src_imm), .reg_write(reg_write),
    .reg_dst_rd(reg_dst_rd), .mem_to_reg(mem_to_reg), .pc_write(pc_write),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0, miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: each fetched word expands into a script of cycle kinds
  int            cur = K_FETCH;
  int            m_cls, waits;
  int            plan[$];
  logic [31:0]   m_ir;
  logic [3:0]    m_ac;
  logic          m_src, m_dst, m_dcare, m_ill, m_to;
  logic [RW-1:0] m_ret;

  function automatic int classify(input logic [31:0] w);
    if (w[31:26] == 6'd0 && w[5:0] == 6'h21) return CL_ADDU;
    if (w[31:26] == 6'h09) return CL_ADDIU;
    if (w[31:26] == 6'h2b) return CL_SW;
`ifdef MIPS_MC_CTRL_LW_EN
    if (w[31:26] == 6'h23) return CL_LW;
`endif
    return CL_ILL;
  endfunction

  task automatic model_reset();
    cur = K_FETCH; waits = 0; plan.delete(); m_cls = CL_ADDIU;
    m_ir = '0; m_ac = '0; m_src = 0; m_dst = 0; m_dcare = 1; m_ill = 0; m_to = 0; m_ret = '0;
  endtask

  task automatic next_kind();
    cur = plan.pop_front();
    waits = 0;
  endtask

  task automatic wait_one();
    waits++;
    if (TO > 0 && waits >= TO) begin
      m_to = 1;
      cur = K_TRAP;
    end
  endtask

  task automatic retire();
    m_ret = RW'((int'(m_ret) + 1) % (1 << RW));
  endtask

  task automatic model_step();
    case (cur)
      K_FETCH: begin
        if (mem_ack) begin
          m_ir = mem_rdata;
          m_cls = classify(mem_rdata);
          plan.delete();
          case (m_cls)
            CL_ADDIU, CL_ADDU: begin plan.push_back(K_EXEC); plan.push_back(K_WB); end
            CL_SW:             begin plan.push_back(K_EXEC); plan.push_back(K_MEMW); end
            CL_LW: begin plan.push_back(K_EXEC); plan.push_back(K_MEMR); plan.push_back(K_WB); end
            default: ;
          endcase
          plan.push_back(m_cls == CL_ILL ? K_TRAP : K_FETCH);
          cur = K_DEC; waits = 0;
        end else wait_one();
      end
      K_DEC: begin
        if (m_cls == CL_ILL) m_ill = 1;
        else begin
          m_ac = (m_cls == CL_ADDU) ? 4'd2 : (m_cls == CL_ADDIU) ? 4'd0 : 4'd1;
          m_src = (m_cls != CL_ADDU);
          m_dst = (m_cls == CL_ADDU);
          m_dcare = (m_cls != CL_SW);
        end
        next_kind();
      end
      K_EXEC: next_kind();
      K_MEMW, K_MEMR: begin
        if (mem_ack) begin
          if (cur == K_MEMW) retire();
          next_kind();
        end else wait_one();
      end
      K_WB: begin retire(); next_kind(); end
      default: ;
    endcase
  endtask

  task automatic check_outputs();
    logic busy;
    busy = rst_n && (cur == K_FETCH || cur == K_MEMW || cur == K_MEMR);
    chk("mem_req", mem_req, busy);
    chk("mem_we", mem_we, rst_n && cur == K_MEMW);
    chk("pc_write", pc_write, cur == K_DEC);
    chk("reg_write", reg_write, cur == K_WB);
    chk("mem_to_reg", mem_to_reg, cur == K_WB && m_cls == CL_LW);
    chk("ir", ir, m_ir);
    chk("imm_ext", imm_ext, 32'($signed(m_ir[15:0])));
    chk("illegal", illegal, m_ill);
    chk("timeout", timeout, m_to);
    chk("retired", retired, m_ret);
    if (!(cur == K_TRAP && m_ill)) begin
      chk("alu_ctrl", alu_ctrl, m_ac);
      chk("alu_src_imm", alu_src_imm, m_src);
      if (m_dcare) chk("reg_dst_rd", reg_dst_rd, m_dst);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) model_reset();
    check_outputs();
    if (rst_n) model_step();
  end

  // ---------------- reactive memory: delay per request, instruction words on fetch
  int          fdly = 0, mdly = 0, wcnt = 0, cur_dly = 0;
  bit          new_req = 1, is_fetch = 0, rand_pool = 0;
  logic [31:0] prog[$];

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int k;
    w = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2: w[31:26] = 6'h09;
      3, 4:    begin w[31:26] = 6'h00; w[5:0] = 6'h21; end
      5, 6:    w[31:26] = 6'h2b;
      7:       w[31:26] = 6'h23;
      8:       w[31:26] = 6'h00;
      default: ;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] next_word();
    if (prog.size() > 0) return prog.pop_front();
    if (rand_pool) return rand_word();
    return 32'h24000001;
  endfunction

  function automatic int pick(input int d);
    if (d >= 0) return d;
    return ($urandom_range(0, 15) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
  endfunction

  always @(posedge clk) begin
    #2;
    if (!rst_n) begin
      mem_ack = 0; mem_rdata = $urandom; new_req = 1;
    end else if (!mem_req) begin
      mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom; new_req = 1;
    end else begin
      if (new_req) begin
        is_fetch = (cur == K_FETCH);
        cur_dly = pick(is_fetch ? fdly : mdly);
        wcnt = 0; new_req = 0;
      end
      if (wcnt >= cur_dly) begin
        mem_ack = 1;
        mem_rdata = is_fetch ? next_word() : $urandom;
        new_req = 1;
      end else begin
        mem_ack = 0; mem_rdata = $urandom; wcnt++;
      end
    end
  end

  // ---------------- activity counters for the directed literal checks
  int cnt_pcw, cnt_rw, cnt_m2r, cnt_req, cnt_wr;
  always @(posedge clk) begin
    #3;
    if (rst_n) begin
      if (pc_write) cnt_pcw++;
      if (reg_write) cnt_rw++;
      if (mem_to_reg) cnt_m2r++;
      if (mem_req) cnt_req++;
      if (mem_req && mem_we) cnt_wr++;
    end
  end

  task automatic clear_counts();
    cnt_pcw = 0; cnt_rw = 0; cnt_m2r = 0; cnt_req = 0; cnt_wr = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst_n = 0;
    @(negedge clk); #1 clear_counts();
    @(posedge clk); #1 rst_n = 1;
  endtask

  task automatic wait_evt(input int which, input int maxc, input string name);
    logic [RW-1:0] r0;
    bit hit;
    r0 = retired; hit = 0;
    for (int i = 0; i < maxc && !hit; i++) begin
      @(negedge clk); #1;
      case (which)
        0:       hit = (retired != r0);
        1:       hit = illegal;
        default: hit = timeout;
      endcase
    end
    if (!hit) begin
      vectors++; miscompares++;
      $display("FAIL %s: event not seen within %0d cycles", name, maxc);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int trap_cyc;
    rst_n = 0; mem_ack = 0; mem_rdata = '0;
    clear_counts();
    prog.push_back(32'h24220005);
    prog.push_back(32'h00430821);
    prog.push_back(32'hAC22FFFC);
    prog.push_back(32'h24000001);
    prog.push_back(32'h24000001);
    prog.push_back(32'h08000000);
    fdly = 0; mdly = 3;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_ir", ir, 0);
    chk("rst_alu_ctrl", alu_ctrl, 0);
    chk("rst_retired", retired, 0);
    chk("rst_flags", {illegal, timeout, pc_write, reg_write}, 0);
    @(posedge clk); #1 rst_n = 1;
    @(negedge clk); #1 chk("first_fetch_req", mem_req, 1);

    wait_evt(0, 20, "addiu_retire");
    chk("addiu_retired", retired, 1);
    chk("addiu_alu_ctrl", alu_ctrl, 4'b0000);
    chk("addiu_src_imm", alu_src_imm, 1);
    chk("addiu_dst_rd", reg_dst_rd, 0);
    chk("addiu_imm_ext", imm_ext, 32'h00000005);
    chk("addiu_reg_write_cycles", cnt_rw, 1);
    chk("addiu_pc_write_cycles", cnt_pcw, 1);

    wait_evt(0, 20, "addu_retire");
    chk("addu_retired", retired, 2);
    chk("addu_alu_ctrl", alu_ctrl, 4'b0010);
    chk("addu_src_imm", alu_src_imm, 0);
    chk("addu_dst_rd", reg_dst_rd, 1);
    chk("addu_reg_write_cycles", cnt_rw, 2);

    wait_evt(0, 30, "sw_retire");
    chk("sw_retired", retired, 3);
    chk("sw_imm_ext", imm_ext, 32'hFFFFFFFC);
    chk("sw_alu_ctrl", alu_ctrl, 4'b0001);
    chk("sw_write_cycles", cnt_wr, 4);
    chk("sw_reg_write_cycles", cnt_rw, 2);

    wait_evt(0, 20, "wrap_retire0");
    chk("wrap_retired0", retired, 0);
    wait_evt(0, 20, "wrap_retire1");
    chk("wrap_retired1", retired, 1);

    wait_evt(1, 20, "j_illegal");
    chk("j_illegal", illegal, 1);
    cnt_req = 0;
    repeat (20) @(negedge clk);
    #1;
    chk("trap_req_cycles", cnt_req, 0);
    chk("trap_illegal_sticky", illegal, 1);
    do_reset();
    @(negedge clk); #1;
    chk("reset_clears_illegal", illegal, 0);
    chk("refetch_req", mem_req, 1);

`ifdef MIPS_MC_CTRL_LW_EN
    prog.push_back(32'h8C220004);
    mdly = 2;
    do_reset();
    wait_evt(0, 30, "lw_retire");
    chk("lw_retired", retired, 1);
    chk("lw_alu_ctrl", alu_ctrl, 4'b0001);
    chk("lw_imm_ext", imm_ext, 32'h00000004);
    chk("lw_mem_to_reg_cycles", cnt_m2r, 1);
    chk("lw_write_cycles", cnt_wr, 0);
`endif

    fdly = 100;
    do_reset();
    wait_evt(2, 20, "fetch_timeout");
    chk("timeout_flag", timeout, 1);
    chk("timeout_req_cycles", cnt_req, TO);
    chk("timeout_req_dropped", mem_req, 0);

    fdly = 3;
    do_reset();
    wait_evt(0, 40, "ack_at_limit_retire");
    chk("ack_at_limit_no_timeout", timeout, 0);
    chk("ack_at_limit_retired", retired, 1);

    rand_pool = 1; fdly = -1; mdly = -1;
    do_reset();
    trap_cyc = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (illegal || timeout) trap_cyc++;
      else trap_cyc = 0;
      if (trap_cyc > 6 || $urandom_range(0, 299) == 0) begin
        do_reset();
        trap_cyc = 0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/mips_mc_ctrl.md
Name: mips_mc_ctrl

Overview:
- Multi-cycle control unit directly upstream of the ALU.
- Fetches an instruction over a req/ack memory handshake and latches it into an internal instruction register.
- Decodes the instruction and sequences FETCH, DECODE, EXEC, MEM and WB.
- Drives the 4-bit ALU control code plus the datapath enables for PC, register file and memory.
- Supported instructions: addiu, sw, addu. Anything else traps.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request waits for ack before trapping; 0 disables the timeout.
- RET_CNT_W, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_rdata  in  32  memory read data, valid when mem_ack=1
- mem_ack  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1=write (sw), 0=read (fetch/lw)
- ir  out  32  instruction register
- imm_ext  out  32  sign-extended ir[15:0]
- alu_ctrl  out  4  ALU code: 0000 addiu, 0001 sw, 0010 addu
- alu_src_imm  out  1  ALU arg2 select: 1=imm_ext, 0=rt data
- reg_write  out  1  register-file write strobe
- reg_dst_rd  out  1  write-back dest select: 1=rd (ir[15:11]), 0=rt (ir[20:16])
- mem_to_reg  out  1  write-back data select: 1=memory data, 0=ALU result
- pc_write  out  1  one-cycle PC+4 strobe
- illegal  out  1  sticky trap: bad opcode
- timeout  out  1  sticky trap: memory timeout
- retired  out  RET_CNT_W  count of completed instructions

Behaviour:
- Reset (async, rst_n=0):
  - state=FETCH.
  - ir=0.
  - alu_ctrl=0000.
  - All strobes, mem_req, mem_we, flags and retired = 0.
  - First cycle after release: FETCH with mem_req=1.
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Registered Moore outputs except mem_req/mem_we, which are a decode of state.
- FETCH:
  - mem_req=1, mem_we=0.
  - mem_ack is sampled in the same cycle as req (zero-wait allowed).
  - On ack: ir<=mem_rdata, pc_write pulses for 1 cycle, next state DECODE.
- DECODE (1 cycle): classify ir[31:26]/ir[5:0].
  - 000000 with funct 100001 = addu: alu_ctrl=0010, alu_src_imm=0, reg_dst_rd=1.
  - 001001 = addiu: alu_ctrl=0000, alu_src_imm=1, reg_dst_rd=0.
  - 101011 = sw: alu_ctrl=0001, alu_src_imm=1.
  - Anything else: illegal<=1, next state TRAP.
- alu_ctrl, alu_src_imm and reg_dst_rd are registered at the end of DECODE and held stable through EXEC/MEM/WB until the next DECODE.
- EXEC (1 cycle): ALU evaluates; external ALUOut is latched on this edge. Next state: WB for addiu/addu, MEM for sw.
- MEM:
  - mem_req=1, mem_we=1, held until ack.
  - On ack: retired++ and next state FETCH.
- WB: reg_write=1 for exactly one cycle, retired++, next state FETCH.
- Zero-wait latency:
  - addu/addiu: 4 cycles per instruction.
  - sw: 4 cycles.
- Timeout (MEM_TIMEOUT>0):
  - A wait counter clears on entering FETCH/MEM and increments each cycle req=1 and ack=0.
  - When the counter reaches MEM_TIMEOUT with no ack: timeout<=1, next state TRAP.
  - An ack in the same cycle the count hits the limit wins; no trap.
- TRAP:
  - Terminal until reset.
  - mem_req=0, all strobes 0, flags stay set.
  - mem_ack is ignored.
- retired wraps modulo 2^RET_CNT_W with no saturation.
- imm_ext is combinational from ir: {{16{ir[15]}},ir[15:0]}.
- mem_ack outside FETCH/MEM is ignored.
- Reset mid-request drops mem_req immediately (async).

Optional Feature:
- Macro: MIPS_MC_CTRL_LW_EN.
- Defined:
  - Opcode 100011 (lw) is legal.
  - DECODE sets alu_ctrl=0001, alu_src_imm=1, reg_dst_rd=0.
  - EXEC goes to MEM as a read (mem_we=0).
  - On ack the state goes to WB with mem_to_reg=1 during WB.
  - Latency: 5 cycles at zero wait.
- Undefined: 100011 is illegal, and mem_to_reg is constant 0.

Test Plan:
- Reset, then mem_rdata=0x24220005 (addiu) with immediate ack:
  - Cycle sequence FETCH, DECODE, EXEC, WB.
  - alu_ctrl=0000, alu_src_imm=1, reg_dst_rd=0, imm_ext=0x00000005.
  - reg_write high for 1 cycle; retired=1; pc_write high for exactly 1 cycle.
- Fetch 0x00430821 (addu): alu_ctrl=0010, alu_src_imm=0, reg_dst_rd=1, one reg_write, retired increments.
- Fetch 0xAC22FFFC (sw), memory ack delayed 3 cycles in MEM:
  - imm_ext=0xFFFFFFFC, alu_ctrl=0001.
  - mem_req=mem_we=1 for 4 cycles; no reg_write; retired increments on ack.
- Fetch 0x08000000 (j):
  - illegal=1 and state TRAP after DECODE.
  - mem_req stays 0 for 20 cycles despite mem_ack toggling.
  - Async rst_n pulse clears illegal and a new fetch starts.
- MEM_TIMEOUT=4, never ack during fetch:
  - timeout=1 after 4 waiting cycles, mem_req drops.
  - Repeat with ack on the 4th waiting cycle: no trap.
- RET_CNT_W=2, run 5 addiu instructions: retired sequence 1,2,3,0,1. With MIPS_MC_CTRL_LW_EN, 0x8C220004 gives a read MEM then WB with mem_to_reg=1.
